// File: rtl/wrap_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : wrap_ctrl
// Description : Sequencing controller for the 8-to-16-bit byte wrapper.
//               Pulls low/high byte pairs from a shared 8-bit bus under a
//               valid/ready handshake, drives the datapath ld8/inccnt/rstcnt
//               strobes, presents each assembled word to the accelerator
//               and pulses done after NWORDS words.
// Revision    : 1.0 - initial release
// ============================================================================
module wrap_ctrl #(
  parameter int NWORDS = 4,
  parameter int WCW    = 3
) (
  input  logic           clk,
  input  logic           rst,        // asynchronous, active-low
  input  logic           start,
  input  logic           abort,
  input  logic           bus_valid,
  output logic           bus_ready,
  output logic           ld8,
  output logic           inccnt,
  output logic           rstcnt,
  output logic           xin_valid,
  input  logic           acc_ready,
  output logic [WCW-1:0] word_idx,
  output logic           busy,
  output logic           done
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    INIT    = 3'd1,
    LOAD_LO = 3'd2,
    LOAD_HI = 3'd3,
    PRESENT = 3'd4,
    DONE    = 3'd5
  } state_t;

  // Index of the final word; reaching it in PRESENT ends the transfer.
  localparam logic [WCW-1:0] LAST_IDX = WCW'(NWORDS - 1);

  state_t         state;
  state_t         state_next;
  logic [WCW-1:0] idx;
  logic [WCW-1:0] idx_next;

  // State and word index registers, cleared asynchronously while rst is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
    end
  end

  // Next-state and strobe decode; abort outranks every other transition.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    bus_ready  = 1'b0;
    ld8        = 1'b0;
    inccnt     = 1'b0;
    rstcnt     = 1'b0;
    xin_valid  = 1'b0;
    done       = 1'b0;
    busy       = (state != IDLE);

    if ((state != IDLE) && abort) begin
      // Drop back to IDLE with the datapath counter cleared and no
      // byte taken from the bus in this cycle.
      rstcnt     = 1'b1;
      idx_next   = '0;
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start && !abort) begin
            state_next = INIT;
          end
        end
        INIT: begin
          rstcnt     = 1'b1;
          idx_next   = '0;
          state_next = LOAD_LO;
        end
        LOAD_LO: begin
          bus_ready = 1'b1;
          if (bus_valid) begin
            ld8        = 1'b1;
            inccnt     = 1'b1;
            state_next = LOAD_HI;
          end
        end
        LOAD_HI: begin
          bus_ready = 1'b1;
          if (bus_valid) begin
            ld8        = 1'b1;
            inccnt     = 1'b1;
            state_next = PRESENT;
          end
        end
        PRESENT: begin
          xin_valid = 1'b1;
          if (acc_ready) begin
            if (idx == LAST_IDX) begin
              state_next = DONE;
            end else begin
              idx_next   = idx + WCW'(1);
              rstcnt     = 1'b1;
              state_next = LOAD_LO;
            end
          end
        end
        DONE: begin
          done       = 1'b1;
          rstcnt     = 1'b1;
          state_next = IDLE;
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  // The word index is presented straight from its register.
  assign word_idx = idx;

endmodule
`default_nettype wire

// File: tb/tb_wrap_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_wrap_ctrl
// Description : Self-checking bench for wrap_ctrl. Two instances (NWORDS=4
//               and NWORDS=1) share one set of inputs; each is compared every
//               cycle against a transaction-level model built from byte and
//               word counters, plus directed latency and count checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wrap_ctrl;

  localparam int WCW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic start;
  logic abort;
  logic bus_valid;
  logic acc_ready;
  logic [1:0] bus_ready;
  logic [1:0] ld8;
  logic [1:0] inccnt;
  logic [1:0] rstcnt;
  logic [1:0] xin_valid;
  logic [1:0] busy;
  logic [1:0] done;
  logic [WCW-1:0] wi0;
  logic [WCW-1:0] wi1;

  wrap_ctrl #(.NWORDS(4), .WCW(WCW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .bus_valid (bus_valid),
    .bus_ready (bus_ready[0]),
    .ld8       (ld8[0]),
    .inccnt    (inccnt[0]),
    .rstcnt    (rstcnt[0]),
    .xin_valid (xin_valid[0]),
    .acc_ready (acc_ready),
    .word_idx  (wi0),
    .busy      (busy[0]),
    .done      (done[0])
  );

  wrap_ctrl #(.NWORDS(1), .WCW(WCW)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .bus_valid (bus_valid),
    .bus_ready (bus_ready[1]),
    .ld8       (ld8[1]),
    .inccnt    (inccnt[1]),
    .rstcnt    (rstcnt[1]),
    .xin_valid (xin_valid[1]),
    .acc_ready (acc_ready),
    .word_idx  (wi1),
    .busy      (busy[1]),
    .done      (done[1])
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int nw [2] = '{4, 1};

  // Transaction model: active transfer, pending init/done cycles,
  // bytes held for the current word, words accepted, reported index.
  bit m_act  [2];
  bit m_init [2];
  bit m_done [2];
  int m_nb   [2];
  int m_wa   [2];
  int m_wi   [2];

  int done_at [2];
  int ld8_cnt [2];
  int xv_cnt  [2];
  int xv_idx2 [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_act[d]  = 1'b0;
      m_init[d] = 1'b0;
      m_done[d] = 1'b0;
      m_nb[d]   = 0;
      m_wa[d]   = 0;
      m_wi[d]   = 0;
    end
  endtask

  task automatic clear_stats();
    for (int d = 0; d < 2; d++) begin
      done_at[d] = -1;
      xv_cnt[d]  = 0;
      xv_idx2[d] = 0;
    end
  endtask

  task automatic check_cycle();
    for (int d = 0; d < 2; d++) begin
      logic e_br, e_ld, e_rc, e_xv, e_busy, e_done;
      bit chk_br;
      logic [WCW-1:0] wi;
      string pre;
      e_br = 0; e_ld = 0; e_rc = 0; e_xv = 0; e_busy = 0; e_done = 0;
      chk_br = 1'b1;
      wi  = (d == 0) ? wi0 : wi1;
      pre = $sformatf("n%0d_c%0d_", nw[d], cyc);
      if (rst && m_act[d]) begin
        e_busy = 1'b1;
        if (abort) begin
          e_rc   = 1'b1;
          chk_br = 1'b0;
        end else if (m_init[d]) begin
          e_rc = 1'b1;
        end else if (m_done[d]) begin
          e_done = 1'b1;
          e_rc   = 1'b1;
        end else if (m_nb[d] < 2) begin
          e_br = 1'b1;
          e_ld = bus_valid;
        end else begin
          e_xv = 1'b1;
          e_rc = acc_ready && (m_wa[d] != nw[d] - 1);
        end
      end
      if (chk_br) chk({pre, "bus_ready"}, 32'(bus_ready[d]), 32'(e_br));
      chk({pre, "ld8"},       32'(ld8[d]),       32'(e_ld));
      chk({pre, "inccnt"},    32'(inccnt[d]),    32'(e_ld));
      chk({pre, "rstcnt"},    32'(rstcnt[d]),    32'(e_rc));
      chk({pre, "xin_valid"}, 32'(xin_valid[d]), 32'(e_xv));
      chk({pre, "busy"},      32'(busy[d]),      32'(e_busy));
      chk({pre, "done"},      32'(done[d]),      32'(e_done));
      chk({pre, "word_idx"},  32'(wi),           32'(m_wi[d]));

      if (done[d] === 1'b1) done_at[d] = cyc;
      if (ld8[d] === 1'b1) ld8_cnt[d]++;
      if (xin_valid[d] === 1'b1) begin
        xv_cnt[d]++;
        if (wi == 3'd2) xv_idx2[d]++;
      end
      if (e_done) chk({pre, "bytes_per_transfer"}, 32'(ld8_cnt[d]), 32'(2 * nw[d]));

      if (rst) begin
        if (m_act[d] && abort) begin
          m_act[d] = 0; m_init[d] = 0; m_done[d] = 0; m_wi[d] = 0;
        end else if (!m_act[d]) begin
          if (start && !abort) begin
            m_act[d]   = 1'b1;
            m_init[d]  = 1'b1;
            ld8_cnt[d] = 0;
          end
        end else if (m_init[d]) begin
          m_init[d] = 0; m_nb[d] = 0; m_wa[d] = 0; m_wi[d] = 0;
        end else if (m_done[d]) begin
          m_done[d] = 0;
          m_act[d]  = 0;
        end else if (m_nb[d] < 2) begin
          if (bus_valid) m_nb[d]++;
        end else if (acc_ready) begin
          if (m_wa[d] == nw[d] - 1) begin
            m_done[d] = 1'b1;
          end else begin
            m_wa[d]++;
            m_wi[d]++;
            m_nb[d] = 0;
          end
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_cycle();
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic a, input logic bv, input logic ar);
    start     = s;
    abort     = a;
    bus_valid = bv;
    acc_ready = ar;
    tick();
  endtask

  initial begin
    int s;
    rst = 1'b0; start = 0; abort = 0; bus_valid = 0; acc_ready = 0;
    model_reset();
    clear_stats();
    ld8_cnt = '{0, 0};

    // Reset state
    drive(0, 0, 0, 0);
    drive(0, 0, 1, 1);
    rst = 1'b1;
    drive(0, 0, 0, 0);

    // Basic transfer: 4 words done at +14, single word done at +5
    clear_stats();
    s = cyc;
    drive(1, 0, 1, 1);
    repeat (16) drive(0, 0, 1, 1);
    chk("basic_done_cycle", 32'(done_at[0] - s), 32'd14);
    chk("n1_done_cycle",    32'(done_at[1] - s), 32'd5);
    chk("basic_xin_cycles", 32'(xv_cnt[0]), 32'd4);
    chk("n1_xin_cycles",    32'(xv_cnt[1]), 32'd1);

    // Bus stall of 5 cycles in LOAD_HI delays done by 5
    clear_stats();
    s = cyc;
    drive(1, 0, 1, 1);
    drive(0, 0, 1, 1);
    drive(0, 0, 1, 1);
    repeat (5) drive(0, 0, 0, 1);
    repeat (14) drive(0, 0, 1, 1);
    chk("stall_done_cycle",    32'(done_at[0] - s), 32'd19);
    chk("stall_n1_done_cycle", 32'(done_at[1] - s), 32'd10);

    // Accelerator backpressure on word 2 for 3 cycles
    clear_stats();
    s = cyc;
    drive(1, 0, 1, 1);
    repeat (9) drive(0, 0, 1, 1);
    repeat (3) drive(0, 0, 1, 0);
    repeat (8) drive(0, 0, 1, 1);
    chk("bp_done_cycle",  32'(done_at[0] - s), 32'd17);
    chk("bp_word2_hold",  32'(xv_idx2[0]), 32'd4);

    // Abort while presenting word 1, then a clean transfer
    clear_stats();
    s = cyc;
    drive(1, 0, 1, 1);
    repeat (6) drive(0, 0, 1, 1);
    drive(0, 1, 1, 1);
    repeat (3) drive(0, 0, 1, 1);
    chk("abort_no_done", 32'(done_at[0]), 32'hFFFF_FFFF);
    chk("abort_word_idx", 32'(wi0), 32'd0);
    chk("abort_idle", 32'(busy[0]), 32'd0);
    clear_stats();
    s = cyc;
    drive(1, 0, 1, 1);
    repeat (16) drive(0, 0, 1, 1);
    chk("post_abort_done_cycle", 32'(done_at[0] - s), 32'd14);

    // Asynchronous reset in LOAD_LO, then start while busy is ignored
    clear_stats();
    drive(1, 0, 1, 1);
    drive(0, 0, 1, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_outputs0", {24'd0, bus_ready[0], ld8[0], inccnt[0], rstcnt[0],
                               xin_valid[0], busy[0], done[0], 1'b0}, 32'd0);
    chk("async_rst_word_idx", 32'(wi0), 32'd0);
    chk("async_rst_outputs1", {25'd0, bus_ready[1], ld8[1], rstcnt[1],
                               xin_valid[1], busy[1], done[1]}, 32'd0);
    model_reset();
    drive(0, 0, 1, 1);
    drive(0, 0, 1, 1);
    rst = 1'b1;
    drive(0, 0, 0, 0);
    chk("rst_no_done", 32'(done_at[0]), 32'hFFFF_FFFF);
    clear_stats();
    s = cyc;
    drive(1, 0, 1, 1);
    repeat (4) drive(0, 0, 1, 1);
    drive(1, 0, 1, 1);
    repeat (12) drive(0, 0, 1, 1);
    chk("busy_start_done_cycle", 32'(done_at[0] - s), 32'd14);
    chk("busy_start_words",      32'(xv_cnt[0]), 32'd4);

    // Randomized traffic against the model
    repeat (500) begin
      drive(($urandom_range(0, 7) == 0), ($urandom_range(0, 49) == 0),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0));
    end
    repeat (20) drive(0, 0, 1, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
